adder_result_accumulator: RTL and testbench

Downstream stage of the 2-bit adder: samples the adder's 3-bit result `{C,S}` (value 0–6) on a debounced push-button press and adds it into a running total. A second button clears the total. Drives the total, a sticky overflow flag and a press counter to the board LEDs. The total counts decimal 0–255 at the default width.

---
 rtl/adder_result_accumulator_pkg.sv | 14 +
 rtl/adder_result_accumulator_if.sv | 23 ++
 rtl/adder_result_accumulator_debounce.sv | 62 ++++++
 rtl/adder_result_accumulator.sv | 104 ++++++++++
 tb/tb_adder_result_accumulator.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/adder_result_accumulator_pkg.sv
// Shared types and constants for the adder result accumulator: FSM state
// encoding and synchronizer depth.
package accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADD      = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_CLEAR    = 2'd3
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/adder_result_accumulator_if.sv
// Board-facing bundle of the accumulator: adder operand, raw buttons and LED outputs.
interface adder_result_accumulator_if #(
    parameter int TOTAL_W = 8
);
    logic               c_in;
    logic [1:0]         s_in;
    logic               btn_add;
    logic               btn_clr;
    logic [TOTAL_W-1:0] total;
    logic               ovf;
    logic [3:0]         add_cnt;
    logic               busy;

    modport master (
        output c_in, s_in, btn_add, btn_clr,
        input  total, ovf, add_cnt, busy
    );

    modport slave (
        input  c_in, s_in, btn_add, btn_clr,
        output total, ovf, add_cnt, busy
    );
endinterface

// File: rtl/adder_result_accumulator_debounce.sv
// Button conditioner: synchronizer, debounce counter and rising-edge detector.
// Stays disarmed after reset until the button has been seen low for DB_CYCLES.
module btn_debounce
    import accum_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   level_reg;
    logic                   level_d_reg;
    logic                   armed_reg;
    logic                   synced;

    assign synced = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= '0;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
            level_d_reg <= level_reg;
            if (!armed_reg) begin
                // A button held through reset must be released before it can press.
                level_reg <= 1'b0;
                if (synced) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    armed_reg <= 1'b1;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else if (synced != level_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    level_reg <= synced;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;
    assign rise  = level_reg & ~level_d_reg;
endmodule

// File: rtl/adder_result_accumulator.sv
// Running total of the 2-bit adder result, stepped by a debounced add button.
// Define ACC_SATURATE_EN to clamp at the maximum instead of wrapping.
module adder_result_accumulator
    import accum_pkg::*;
#(
    parameter int TOTAL_W   = 8,
    parameter int DB_CYCLES = 1000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    adder_result_accumulator_if.slave   bus
);
    logic               add_level;
    logic               add_p;
    logic               unused_clr_level;
    logic               clr_p;
    state_t             state_reg;
    logic [TOTAL_W-1:0] total_reg;
    logic [TOTAL_W-1:0] op_reg;
    logic               ovf_reg;
    logic [3:0]         add_cnt_reg;
    logic               busy_reg;
    logic [TOTAL_W:0]   sum;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_add (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_add),
        .level   (add_level),
        .rise    (add_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_clr),
        .level   (unused_clr_level),
        .rise    (clr_p)
    );

    assign sum = {1'b0, total_reg} + {1'b0, op_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            total_reg   <= '0;
            op_reg      <= '0;
            ovf_reg     <= 1'b0;
            add_cnt_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Clear has priority; a coincident add is dropped.
                    if (clr_p) begin
                        state_reg <= ST_CLEAR;
                        busy_reg  <= 1'b1;
                    end else if (add_p) begin
                        op_reg    <= TOTAL_W'({bus.c_in, bus.s_in});
                        state_reg <= ST_ADD;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_ADD: begin
`ifdef ACC_SATURATE_EN
                    if (sum[TOTAL_W]) begin
                        total_reg <= '1;
                        ovf_reg   <= 1'b1;
                    end else begin
                        total_reg <= sum[TOTAL_W-1:0];
                    end
`else
                    total_reg <= sum[TOTAL_W-1:0];
                    if (sum[TOTAL_W]) ovf_reg <= 1'b1;
`endif
                    add_cnt_reg <= add_cnt_reg + 4'd1;
                    state_reg   <= ST_WAIT_REL;
                    busy_reg    <= 1'b1;
                end
                ST_WAIT_REL: begin
                    if (clr_p) begin
                        state_reg <= ST_CLEAR;
                        busy_reg  <= 1'b1;
                    end else if (!add_level) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    total_reg   <= '0;
                    ovf_reg     <= 1'b0;
                    add_cnt_reg <= '0;
                    state_reg   <= ST_IDLE;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.total   = total_reg;
    assign bus.ovf     = ovf_reg;
    assign bus.add_cnt = add_cnt_reg;
    assign bus.busy    = busy_reg;
endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator with DB_CYCLES=4, TOTAL_W=8.
module tb_adder_result_accumulator;
    localparam int TW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adder_result_accumulator_if #(.TOTAL_W(TW)) bus ();

    adder_result_accumulator #(.TOTAL_W(TW), .DB_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_add(input logic [2:0] op);
        @(negedge clk);
        {bus.c_in, bus.s_in} = op;
        bus.btn_add = 1'b1;
        repeat (12) @(negedge clk);
        bus.btn_add = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_clr();
        @(negedge clk);
        bus.btn_clr = 1'b1;
        repeat (12) @(negedge clk);
        bus.btn_clr = 1'b0;
        repeat (12) @(negedge clk);
    endtask

`ifdef ACC_SATURATE_EN
    localparam logic [31:0] WRAP43 = 32'd255;
    localparam logic [31:0] WRAP44 = 32'd255;
`else
    localparam logic [31:0] WRAP43 = 32'd2;
    localparam logic [31:0] WRAP44 = 32'd6;
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.c_in    = 1'b1;
        bus.s_in    = 2'b10;
        bus.btn_add = 1'b1;
        bus.btn_clr = 1'b0;

        // Reset state, add button held across reset release
        repeat (3) @(negedge clk);
        chk("rst_total", 32'(bus.total), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_add_cnt", 32'(bus.add_cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("held_total", 32'(bus.total), 32'd0);
        chk("held_add_cnt", 32'(bus.add_cnt), 32'd0);
        chk("held_busy", 32'(bus.busy), 32'd0);
        bus.btn_add = 1'b0;
        repeat (20) @(negedge clk);

        // Clean press of 3'b110: total updates on the 8th edge after the raw rise
        bus.btn_add = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("lat7_total", 32'(bus.total), 32'd0);
        chk("lat7_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        chk("lat8_total", 32'(bus.total), 32'd6);
        chk("lat8_add_cnt", 32'(bus.add_cnt), 32'd1);
        repeat (4) @(negedge clk);
        bus.btn_add = 1'b0;
        repeat (12) @(negedge clk);
        chk("rel_busy", 32'(bus.busy), 32'd0);
        chk("rel_total", 32'(bus.total), 32'd6);

        // Bounce every 2 cycles for 20 cycles, then a steady press of 1
        {bus.c_in, bus.s_in} = 3'b001;
        for (int i = 0; i < 10; i++) begin
            bus.btn_add = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        chk("bounce_total", 32'(bus.total), 32'd6);
        chk("bounce_add_cnt", 32'(bus.add_cnt), 32'd1);
        bus.btn_add = 1'b1;
        repeat (12) @(negedge clk);
        bus.btn_add = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_hold_total", 32'(bus.total), 32'd7);
        chk("bounce_hold_add_cnt", 32'(bus.add_cnt), 32'd2);

        // Clear button
        do_clr();
        chk("clr_total", 32'(bus.total), 32'd0);
        chk("clr_ovf", 32'(bus.ovf), 32'd0);
        chk("clr_add_cnt", 32'(bus.add_cnt), 32'd0);

        // 43 x 6 = 258 overflows, then one more add of 4
        for (int i = 0; i < 43; i++) do_add(3'b110);
        chk("wrap43_total", 32'(bus.total), WRAP43);
        chk("wrap43_ovf", 32'(bus.ovf), 32'd1);
        chk("wrap43_add_cnt", 32'(bus.add_cnt), 32'd11);
        do_add(3'b100);
        chk("wrap44_total", 32'(bus.total), WRAP44);
        chk("wrap44_ovf", 32'(bus.ovf), 32'd1);
        chk("wrap44_add_cnt", 32'(bus.add_cnt), 32'd12);

        // Build total 20, then press add and clear together
        do_clr();
        do_add(3'b110);
        do_add(3'b110);
        do_add(3'b110);
        do_add(3'b010);
        chk("pre_sim_total", 32'(bus.total), 32'd20);
        chk("pre_sim_add_cnt", 32'(bus.add_cnt), 32'd4);
        @(negedge clk);
        bus.btn_add = 1'b1;
        bus.btn_clr = 1'b1;
        repeat (12) @(negedge clk);
        chk("sim_total", 32'(bus.total), 32'd0);
        chk("sim_ovf", 32'(bus.ovf), 32'd0);
        chk("sim_add_cnt", 32'(bus.add_cnt), 32'd0);
        chk("sim_busy", 32'(bus.busy), 32'd0);
        bus.btn_add = 1'b0;
        bus.btn_clr = 1'b0;
        repeat (12) @(negedge clk);

        // Long hold of 3: one add, busy until debounced release
        {bus.c_in, bus.s_in} = 3'b011;
        bus.btn_add = 1'b1;
        repeat (25) @(negedge clk);
        chk("hold_busy_mid", 32'(bus.busy), 32'd1);
        repeat (25) @(negedge clk);
        chk("hold_total", 32'(bus.total), 32'd3);
        chk("hold_add_cnt", 32'(bus.add_cnt), 32'd1);
        bus.btn_add = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("hold_busy_e6", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        chk("hold_busy_e7", 32'(bus.busy), 32'd0);
        chk("hold_total_end", 32'(bus.total), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
